// File: rtl/operand_loader.sv
// -----------------------------------------------------------------------------
// operand_loader
//
// Front-end loader for the calculator's operand memory. It takes a stream of
// DATA_W-bit operands over a valid/ready handshake and packs each consecutive
// pair into one 2*DATA_W memory word. The first operand of a pair goes to the
// low half (SRAM A) and the second to the high half (SRAM B). Each word is
// written to the shared SRAM write port, walking a programmed, inclusive
// address range that may wrap through zero. done_o pulses once the final word
// has been written; it tells the downstream controller that memory is
// populated.
//
// Optional feature macro: OPERAND_LOADER_CKSUM_EN
//   defined   -> cksum_o accumulates the sum mod 2^DATA_W of the operands
//                accepted since the last accepted start
//   undefined -> no accumulator is built and cksum_o is tied to zero
//
// Ports
//   clk_i        : clock; all state changes on the rising edge
//   rst_i        : asynchronous active-low reset; clears all state
//   start_i      : start pulse, honoured only in IDLE
//   abort_i      : cancels a load in any non-IDLE state
//   base_addr_i  : first write address, captured on an accepted start
//   end_addr_i   : last write address (inclusive), captured on an accepted start
//   in_valid_i   : operand valid
//   in_data_i    : operand
//   in_ready_o   : loader can accept an operand (LOW/HIGH states)
//   write_o      : SRAM write strobe, active-high
//   w_addr_o     : SRAM write address
//   w_data_o     : packed write word {second, first}
//   busy_o       : high in every state except IDLE
//   done_o       : one-cycle pulse after the final word is written
//   cksum_o      : operand checksum (zero when the feature is disabled)
// -----------------------------------------------------------------------------
module operand_loader #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic [ADDR_W-1:0]     base_addr_i,
    input  logic [ADDR_W-1:0]     end_addr_i,
    input  logic                  in_valid_i,
    input  logic [DATA_W-1:0]     in_data_i,
    output logic                  in_ready_o,
    output logic                  write_o,
    output logic [ADDR_W-1:0]     w_addr_o,
    output logic [2*DATA_W-1:0]   w_data_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DATA_W-1:0]     cksum_o
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOW   = 3'd1;
    localparam logic [2:0] S_HIGH  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]          state_q, state_d;
    logic [ADDR_W-1:0]   addr_q,  addr_d;
    logic [ADDR_W-1:0]   end_q,   end_d;
    logic [2*DATA_W-1:0] data_q,  data_d;

    logic                start_acc_s;
    logic                accept_s;

    // A start is honoured only from IDLE. An operand counts as accepted only
    // when no abort arrives in the same cycle, because an abort discards any
    // partial word.
    assign start_acc_s = (state_q == S_IDLE) && start_i;
    assign accept_s    = in_ready_o && in_valid_i && !abort_i;

    // Next-state and datapath decode for the load sequence.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        end_d   = end_q;
        data_d  = data_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    addr_d  = base_addr_i;
                    end_d   = end_addr_i;
                    state_d = S_LOW;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOW: begin
                if (abort_i) begin
                    state_d = S_IDLE;
                end else if (in_valid_i) begin
                    data_d[DATA_W-1:0] = in_data_i;
                    state_d            = S_HIGH;
                end else begin
                    state_d = S_LOW;
                end
            end
            S_HIGH: begin
                if (abort_i) begin
                    state_d = S_IDLE;
                end else if (in_valid_i) begin
                    data_d[2*DATA_W-1:DATA_W] = in_data_i;
                    state_d                   = S_WRITE;
                end else begin
                    state_d = S_HIGH;
                end
            end
            S_WRITE: begin
                // The strobe for this word is already on the port. An abort
                // lets it finish but skips both the address step and DONE.
                if (abort_i) begin
                    state_d = S_IDLE;
                end else if (addr_q == end_q) begin
                    state_d = S_DONE;
                end else begin
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = S_LOW;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            end_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            end_q   <= end_d;
            data_q  <= data_d;
        end
    end

`ifdef OPERAND_LOADER_CKSUM_EN
    logic [DATA_W-1:0] cksum_q, cksum_d;

    // Running operand sum: cleared on an accepted start and bumped on each
    // accepted operand. It holds through an abort, DONE and IDLE.
    always_comb begin
        cksum_d = cksum_q;
        if (start_acc_s) begin
            cksum_d = '0;
        end else if (accept_s) begin
            cksum_d = cksum_q + in_data_i;
        end else begin
            cksum_d = cksum_q;
        end
    end

    // Checksum register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cksum_q <= '0;
        end else begin
            cksum_q <= cksum_d;
        end
    end

    assign cksum_o = cksum_q;
`else
    logic unused_s;
    assign unused_s = start_acc_s ^ accept_s;
    assign cksum_o  = '0;
`endif

    // Status outputs are plain decodes of the state register. Because that
    // register resets asynchronously, write_o drops the moment rst_i asserts.
    assign in_ready_o = (state_q == S_LOW) || (state_q == S_HIGH);
    assign write_o    = (state_q == S_WRITE);
    assign busy_o     = (state_q != S_IDLE);
    assign done_o     = (state_q == S_DONE);
    assign w_addr_o   = addr_q;
    assign w_data_o   = data_q;

endmodule

// File: tb/tb_operand_loader.sv
module tb_operand_loader;
    localparam int AW = 9;
    localparam int DW = 32;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            start_i;
    logic            abort_i;
    logic [AW-1:0]   base_addr_i;
    logic [AW-1:0]   end_addr_i;
    logic            in_valid_i;
    logic [DW-1:0]   in_data_i;
    logic            in_ready_o;
    logic            write_o;
    logic [AW-1:0]   w_addr_o;
    logic [2*DW-1:0] w_data_o;
    logic            busy_o;
    logic            done_o;
    logic [DW-1:0]   cksum_o;

    int total = 0;
    int bad   = 0;
    logic [31:0] preset[$];

    operand_loader #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
        .base_addr_i(base_addr_i), .end_addr_i(end_addr_i),
        .in_valid_i(in_valid_i), .in_data_i(in_data_i), .in_ready_o(in_ready_o),
        .write_o(write_o), .w_addr_o(w_addr_o), .w_data_o(w_data_o),
        .busy_o(busy_o), .done_o(done_o), .cksum_o(cksum_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Expected checksum output given the true operand sum.
    function automatic logic [31:0] exp_ck(input logic [31:0] s);
`ifdef OPERAND_LOADER_CKSUM_EN
        return s;
`else
        return 32'd0;
`endif
    endfunction

    // One full load. vmode: 0 = valid held high, 1 = random valid,
    // 2 = valid pattern 1,0,0,1 repeating.
    task automatic run_load(input logic [8:0] base, input logic [8:0] last, input int vmode);
        logic [8:0]  diff;
        logic [8:0]  ea;
        logic [31:0] ops[$];
        logic [31:0] sum;
        int          nwords;
        int          idx;
        int          wr;
        int          cyc;
        int          vcount;
        bit          fin;
        bit          last_wr;
        bit          v;
        diff   = last - base;
        nwords = int'(diff) + 1;
        ops    = {};
        for (int i = 0; i < 2 * nwords; i++) begin
            if (preset.size() != 0) ops.push_back(preset.pop_front());
            else ops.push_back($urandom);
        end
        preset  = {};
        sum     = 32'd0;
        idx     = 0;
        wr      = 0;
        cyc     = 0;
        vcount  = 0;
        fin     = 1'b0;
        last_wr = 1'b0;
        @(negedge clk_i);
        start_i     = 1'b1;
        base_addr_i = base;
        end_addr_i  = last;
        in_valid_i  = 1'b0;
        @(negedge clk_i);
        start_i     = 1'b0;
        base_addr_i = 9'($urandom);
        end_addr_i  = 9'($urandom);
        while (!fin && cyc < 400) begin
            if (write_o) begin
                if (wr < nwords) begin
                    ea = base + 9'(wr);
                    chk("waddr", 64'(w_addr_o), 64'(ea));
                    chk("wdata", w_data_o, {ops[2*wr+1], ops[2*wr]});
                    chk("early_write", 64'(idx >= 2 * (wr + 1)), 64'd1);
                end else begin
                    chk("extra_write", 64'(write_o), 64'd0);
                end
                wr++;
            end
            if (done_o) begin
                chk("done_words", 64'(wr), 64'(nwords));
                chk("done_after_write", 64'(last_wr), 64'd1);
                chk("cksum", 64'(cksum_o), 64'(exp_ck(sum)));
                if (vmode == 0) chk("done_latency", 64'(cyc), 64'(3 * nwords));
                fin = 1'b1;
            end
            chk("ready", 64'(in_ready_o), 64'(!(write_o || done_o)));
            chk("busy", 64'(busy_o), 64'd1);
            last_wr = write_o;
            if (!fin) begin
                case (vmode)
                    0:       v = 1'b1;
                    1:       v = 1'($urandom_range(0, 1));
                    default: v = ((vcount % 4) == 0) || ((vcount % 4) == 3);
                endcase
                vcount++;
                if (idx >= 2 * nwords) v = 1'b0;
                in_valid_i = v;
                in_data_i  = v ? ops[idx] : $urandom;
                if (v && in_ready_o) begin
                    sum = sum + ops[idx];
                    idx++;
                end
                @(negedge clk_i);
                cyc++;
            end
        end
        if (!fin) chk("timeout", 64'd1, 64'd0);
        in_valid_i = 1'b0;
        @(negedge clk_i);
        ea = last;
        chk("idle_busy", 64'(busy_o), 64'd0);
        chk("idle_done", 64'(done_o), 64'd0);
        chk("hold_addr", 64'(w_addr_o), 64'(ea));
        chk("hold_cksum", 64'(cksum_o), 64'(exp_ck(sum)));
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic [8:0]  rb;
        int          n;
        int          guard;
        rst_i = 1'b0; start_i = 1'b0; abort_i = 1'b0;
        base_addr_i = 9'd0; end_addr_i = 9'd0;
        in_valid_i = 1'b0; in_data_i = 32'd0;
        #2;
        chk("rst_write", 64'(write_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_ready", 64'(in_ready_o), 64'd0);
        chk("rst_addr", 64'(w_addr_o), 64'd0);
        chk("rst_data", w_data_o, 64'd0);
        chk("rst_cksum", 64'(cksum_o), 64'd0);
        @(negedge clk_i);
        rst_i = 1'b1;

        // Basic load: 1,2,3,4 into 0x010..0x011, checksum 0xA.
        preset = {32'h1, 32'h2, 32'h3, 32'h4};
        run_load(9'h010, 9'h011, 0);
        chk("basic_cksum", 64'(cksum_o), 64'(exp_ck(32'hA)));

        // Wrap-around 0x1FF -> 0x000.
        preset = {32'hA, 32'hB, 32'hC, 32'hD};
        run_load(9'h1FF, 9'h000, 0);

        // Backpressure with gaps.
        preset = {32'hDEADBEEF, 32'hCAFEF00D};
        run_load(9'h005, 9'h005, 2);

        // Abort in HIGH after one operand.
        a = $urandom;
        @(negedge clk_i);
        start_i = 1'b1; base_addr_i = 9'h020; end_addr_i = 9'h022;
        @(negedge clk_i);
        start_i = 1'b0; in_valid_i = 1'b1; in_data_i = a;
        @(negedge clk_i);
        chk("abort_in_high_ready", 64'(in_ready_o), 64'd1);
        in_valid_i = 1'b0; abort_i = 1'b1;
        @(negedge clk_i);
        abort_i = 1'b0;
        chk("abort_busy", 64'(busy_o), 64'd0);
        chk("abort_write", 64'(write_o), 64'd0);
        chk("abort_done", 64'(done_o), 64'd0);
        chk("abort_cksum", 64'(cksum_o), 64'(exp_ck(a)));
        @(negedge clk_i);
        chk("abort_done2", 64'(done_o), 64'd0);
        chk("abort_write2", 64'(write_o), 64'd0);

        // Stray start during LOW must be ignored.
        a = $urandom; b = $urandom;
        start_i = 1'b1; base_addr_i = 9'h030; end_addr_i = 9'h030;
        @(negedge clk_i);
        base_addr_i = 9'h100; end_addr_i = 9'h100;
        @(negedge clk_i);
        start_i = 1'b0;
        in_valid_i = 1'b1; in_data_i = a;
        @(negedge clk_i);
        in_data_i = b;
        @(negedge clk_i);
        in_valid_i = 1'b0;
        chk("stray_write", 64'(write_o), 64'd1);
        chk("stray_addr", 64'(w_addr_o), 64'h030);
        chk("stray_data", w_data_o, {b, a});
        @(negedge clk_i);
        chk("stray_done", 64'(done_o), 64'd1);
        chk("stray_cksum", 64'(cksum_o), 64'(exp_ck(a + b)));
        @(negedge clk_i);

        // Reset during WRITE.
        start_i = 1'b1; base_addr_i = 9'h007; end_addr_i = 9'h007;
        @(negedge clk_i);
        start_i = 1'b0; in_valid_i = 1'b1; in_data_i = $urandom;
        guard = 0;
        while (!write_o && guard < 20) begin
            @(negedge clk_i);
            in_data_i = $urandom;
            guard++;
        end
        in_valid_i = 1'b0;
        chk("rst_mid_reached_write", 64'(write_o), 64'd1);
        #1 rst_i = 1'b0;
        #1;
        chk("rst_mid_write", 64'(write_o), 64'd0);
        chk("rst_mid_addr", 64'(w_addr_o), 64'd0);
        chk("rst_mid_data", w_data_o, 64'd0);
        chk("rst_mid_cksum", 64'(cksum_o), 64'd0);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("rst_rel_ready", 64'(in_ready_o), 64'd0);
        chk("rst_rel_busy", 64'(busy_o), 64'd0);

        // Randomized loads, some forced across the wrap point.
        for (int i = 0; i < 20; i++) begin
            n  = $urandom_range(1, 4);
            rb = (i % 4 == 0) ? 9'h1FE : 9'($urandom);
            run_load(rb, rb + 9'(n - 1), 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/operand_loader.md
# operand_loader

Front-end loader that fills the calculator's operand memory before a compute run. Accepts a stream of 32-bit operands over a valid/ready handshake, packs each consecutive pair into one 64-bit memory word (first word to bits [31:0] for SRAM A, second to bits [63:32] for SRAM B), and drives the shared SRAM write port over a programmed address range. Sits directly upstream of the controller/SRAM pair; its `done_o` pulse is the controller's cue that memory is populated.

## Interface
- `ADDR_W`, 9: address width; the SRAM macros are 512 words deep.
- `DATA_W`, 32: operand width; the memory word is `2*DATA_W`.
- `clk_i` in 1: single clock; all state on the rising edge.
- `rst_i` in 1: reset, **asynchronous, active-low**; asserting it clears all state immediately.
- `start_i` in 1: one-cycle start pulse; sampled only in IDLE.
- `abort_i` in 1: cancels a load in any non-IDLE state.
- `base_addr_i` in ADDR_W: first write address; captured on an accepted start.
- `end_addr_i` in ADDR_W: last write address, inclusive; captured on an accepted start.
- `in_valid_i` in 1: operand valid.
- `in_data_i` in DATA_W: operand.
- `in_ready_o` out 1: loader can accept an operand.
- `write_o` out 1: SRAM write strobe, active-high; top level inverts it for `csb0`/`web0`.
- `w_addr_o` out ADDR_W: SRAM write address.
- `w_data_o` out 2*DATA_W: packed write word.
- `busy_o` out 1: high in every state except IDLE.
- `done_o` out 1: one-cycle pulse after the final word is written.
- `cksum_o` out DATA_W: operand checksum (see Configuration).

## Operation
- States: IDLE, LOW, HIGH, WRITE, DONE.
- **IDLE.** `start_i=1` captures `base_addr_i` into `w_addr_o` and `end_addr_i` into an internal register, clears the checksum, then moves to LOW.
- **LOW.** `in_ready_o=1`. A handshake (`in_valid_i && in_ready_o`) latches `in_data_i` into `w_data_o[31:0]` and moves to HIGH.
- **HIGH.** `in_ready_o=1`. A handshake latches `in_data_i` into `w_data_o[63:32]` and moves to WRITE.
- **WRITE.** `write_o=1` and `in_ready_o=0` for exactly one cycle.
  - If `w_addr_o == end`, go to DONE.
  - Otherwise `w_addr_o <= w_addr_o + 1` (modulo 2^ADDR_W, so 511 wraps to 0) and go to LOW.
- **DONE.** `done_o=1` for one cycle, then IDLE. `w_addr_o` and `w_data_o` hold their last values.
- **Address range.**
  - `end < base` wraps through 0; the word count is `(end - base) mod 2^ADDR_W + 1`.
  - `end == base` writes exactly one word.
- **Ignored inputs.**
  - `start_i` is ignored outside IDLE.
  - `in_valid_i` is ignored whenever `in_ready_o=0`.
- **Abort.**
  - In LOW or HIGH: go to IDLE next cycle, discard any partial word, issue no write, no `done_o`.
  - In WRITE: the write already in progress completes, then go to IDLE, no `done_o`.
  - In DONE: `done_o` still pulses.
- **Reset.** `rst_i=0` at any time forces IDLE and sets every output to 0, including `w_addr_o`, `w_data_o` and `cksum_o`. A write in flight is dropped: `write_o` deasserts asynchronously.
- **Arithmetic.** All address and checksum arithmetic is unsigned and wraps; no saturation.

## Timing
- All outputs are registered. `in_ready_o`, `busy_o` and `done_o` are decoded from the state register.
- `write_o` rises in the cycle after the HIGH-state handshake.
- Throughput: 2 operands every 3 cycles at best (LOW, HIGH, WRITE).
- Cycle from accepted `start_i` to first `in_ready_o=1`: 1.
- `done_o` rises the cycle after the final WRITE cycle.
- `in_valid_i` may be held high indefinitely; `in_data_i` must be stable while `in_valid_i=1 && in_ready_o=0`.

## Configuration
- Macro: `OPERAND_LOADER_CKSUM_EN`.
- **Defined.** `cksum_o` accumulates the sum mod 2^DATA_W of every accepted operand since the last accepted start. It updates the cycle after each handshake, is cleared on start, and holds its value through DONE and IDLE. Abort keeps the sum of the operands accepted so far.
- **Undefined.** No accumulator is built and `cksum_o` is tied to 0.

## Test plan
- **Basic load.** base=0x010, end=0x011, operands 0x1,0x2,0x3,0x4 with valid held high → writes {0x2,0x1}@0x010 and {0x4,0x3}@0x011; `done_o` pulses 1 cycle after the second write; `cksum_o`=0xA.
- **Wrap-around.** base=0x1FF, end=0x000, operands 0xA..0xD → writes @0x1FF then @0x000, exactly 2 write pulses; `w_addr_o`=0x000 at DONE.
- **Backpressure and gaps.** base=end=0x005; `in_valid_i` toggles 1,0,0,1 with data 0xDEADBEEF, 0xCAFEF00D → one write {0xCAFEF00D,0xDEADBEEF}@0x005; no `write_o` before the second handshake.
- **Abort and stray start.** Abort in HIGH after one operand → no write, no `done_o`, `busy_o`=0 next cycle. A `start_i` pulse during LOW → ignored; captured addresses unchanged.
- **Reset mid-load.** Drop `rst_i` during WRITE → `write_o`, `w_addr_o`, `w_data_o` and `cksum_o` read 0 immediately. After release, state is IDLE and `in_ready_o`=0.
- **Macro off.** Rerun the basic load without `OPERAND_LOADER_CKSUM_EN` → identical writes and `done_o` timing, `cksum_o`=0 throughout.
